// File: rtl/l1_pkg.sv
// Shared types and address helpers for the L1 lookup/refill sequencing logic.
// Set-index width and way count come from the global core configuration macros.
`ifndef CORE_IDX_WIDTH
`define CORE_IDX_WIDTH 6
`endif
`ifndef L1_WAY_NUM
`define L1_WAY_NUM 4
`endif

package l1_pkg;

  localparam int L1_IDX_W = `CORE_IDX_WIDTH;
  localparam int L1_WAYS  = `L1_WAY_NUM;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_LOOKUP,
    ST_MISS_REQ,
    ST_MISS_WAIT,
    ST_REPLAY
  } l1_state_e;

  // Byte-offset bits inside one line of beats*beat_w bits.
  function automatic int line_offset_w(input int beats, input int beat_w);
    return $clog2(beats * beat_w / 8);
  endfunction

  localparam int LINE_OFFSET_W = line_offset_w(4, 32);

  function automatic logic [L1_IDX_W-1:0] idx_of(input logic [63:0] addr, input int off);
    return L1_IDX_W'(addr >> off);
  endfunction

  function automatic logic [63:0] tag_of(input logic [63:0] addr, input int off);
    return addr >> (off + L1_IDX_W);
  endfunction

endpackage

// File: rtl/l1_miss_timer.sv
// Watchdog counter for the refill wait: counts enabled cycles since the last clear.
// expire is combinational from the count and holds until clear; count saturates at LIMIT.
module l1_miss_timer
#(
  parameter int LIMIT = 1024
)
(
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expire) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expire = (cnt == CW'(LIMIT));

endmodule

// File: rtl/l1_miss_ctrl.sv
// L1 lookup sequencer: hit answers one cycle after accept; a miss fetches, refills and replays the lookup.
// Accepts only in IDLE (one outstanding miss); optional refill watchdog under L1_MISS_TIMEOUT_EN.
module l1_miss_ctrl
  import l1_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int BEAT_W      = 32,
  parameter int LINE_BEATS  = 4,
  parameter int TIMEOUT_CYC = 1024
)
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          core_req_val,
  input  logic [ADDR_W-1:0]             core_req_addr,
  output logic                          core_req_rdy,
  output logic                          core_rsp_val,
  output logic                          core_rsp_err,
  output logic                          lookup_req,
  output logic [`CORE_IDX_WIDTH-1:0]    lookup_idx,
  input  logic                          lookup_ready,
  input  logic                          hit,
  input  logic                          evict_val,
  input  logic [`L1_WAY_NUM-1:0]        way_vect,
  output logic                          mem_req_val,
  output logic [ADDR_W-1:0]             mem_req_addr,
  input  logic                          mem_req_ack,
  input  logic                          mem_rsp_val,
  input  logic [BEAT_W-1:0]             mem_rsp_data,
  output logic                          refill_we,
  output logic [`L1_WAY_NUM-1:0]        refill_way,
  output logic [`CORE_IDX_WIDTH-1:0]    refill_idx,
  output logic [$clog2(LINE_BEATS)-1:0] refill_beat,
  output logic [BEAT_W-1:0]             refill_data,
  output logic                          refill_tag_we,
  output logic                          evict_pulse
);

  localparam int OFF = line_offset_w(LINE_BEATS, BEAT_W);
  localparam int BW  = $clog2(LINE_BEATS);

  l1_state_e                   state;
  logic [ADDR_W-OFF-1:0]       line_q;
  logic [`L1_WAY_NUM-1:0]      way_q;
  logic [BW-1:0]               beat_q;

  logic                        accept;
  logic                        in_wait;
  logic                        beat_fire;
  logic                        last_beat;
  logic                        timeout;
  logic [ADDR_W-1:0]           line_addr;
  logic [`CORE_IDX_WIDTH-1:0]  line_idx;

  assign accept    = (state == ST_IDLE) && core_req_val;
  assign in_wait   = (state == ST_MISS_WAIT);
  assign beat_fire = in_wait && mem_rsp_val;
  assign last_beat = (beat_q == BW'(LINE_BEATS - 1));
  assign line_addr = {line_q, {OFF{1'b0}}};
  assign line_idx  = idx_of(64'(line_addr), OFF);

`ifdef L1_MISS_TIMEOUT_EN
  logic tmr_expire;

  // A beat restarts the window, so only a silent memory trips the watchdog.
  l1_miss_timer #(
    .LIMIT (TIMEOUT_CYC)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (!in_wait || mem_rsp_val),
    .enable (in_wait),
    .expire (tmr_expire)
  );

  assign timeout = in_wait && !mem_rsp_val && tmr_expire;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_INIT;
      line_q <= '0;
      way_q  <= '0;
      beat_q <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          if (lookup_ready) state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (core_req_val) begin
            line_q <= core_req_addr[ADDR_W-1:OFF];
            state  <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (hit) begin
            state <= ST_IDLE;
          end else begin
            way_q <= way_vect;
            state <= ST_MISS_REQ;
          end
        end
        ST_MISS_REQ: begin
          if (mem_req_ack) begin
            beat_q <= '0;
            state  <= ST_MISS_WAIT;
          end
        end
        ST_MISS_WAIT: begin
          if (mem_rsp_val) begin
            beat_q <= beat_q + BW'(1);
            if (last_beat) state <= ST_REPLAY;
          end else if (timeout) begin
            state <= ST_IDLE;
          end
        end
        ST_REPLAY: begin
          state <= ST_LOOKUP;
        end
        default: begin
          state <= ST_INIT;
        end
      endcase
    end
  end

  assign core_req_rdy  = (state == ST_IDLE);
  assign core_rsp_val  = (state == ST_LOOKUP) && hit;
  assign core_rsp_err  = timeout;
  assign evict_pulse   = (state == ST_LOOKUP) && !hit && evict_val;

  // The replay re-presents the latched set so LRU and tag state update through the normal path.
  assign lookup_req    = accept || (state == ST_REPLAY);
  assign lookup_idx    = accept ? idx_of(64'(core_req_addr), OFF) :
                         (state == ST_REPLAY) ? line_idx : '0;

  assign mem_req_val   = (state == ST_MISS_REQ);
  assign mem_req_addr  = mem_req_val ? line_addr : '0;

  assign refill_we     = beat_fire;
  assign refill_way    = beat_fire ? way_q : '0;
  assign refill_idx    = beat_fire ? line_idx : '0;
  assign refill_beat   = beat_fire ? beat_q : '0;
  assign refill_data   = beat_fire ? mem_rsp_data : '0;
  assign refill_tag_we = beat_fire && last_beat;

endmodule

// File: doc/l1_miss_ctrl.md
# l1_miss_ctrl

Sequencing controller for one L1 cache lookup pipeline: LRU unit, tag array and data array. It accepts core read requests and issues lookups. On a miss it fetches the line from memory beat by beat, drives the refill writes, then replays the lookup so the LRU state and tag hit are updated through the normal path. It sits between the core load/fetch port and the L1 arrays, and is the only agent driving the arrays' lookup index.

## Interface
Parameters:
- ADDR_W, 32, core byte-address width
- BEAT_W, 32, memory response data width per beat
- LINE_BEATS, 4, beats per cache line (power of two, ≥2)
- TIMEOUT_CYC, 1024, watchdog limit in MISS_WAIT (used only with macro)

Ports (clock and reset: one clock; reset is asynchronous and active-low):
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- core_req_val  in  1  core read request
- core_req_addr  in  ADDR_W  byte address
- core_req_rdy  out  1  request accepted when val&rdy
- core_rsp_val  out  1  one-cycle hit pulse; data array output valid
- core_rsp_err  out  1  one-cycle error pulse (timeout)
- lookup_req  out  1  to LRU/tag/data read port
- lookup_idx  out  `CORE_IDX_WIDTH  set index
- lookup_ready  in  1  LRU hardware clean finished
- hit  in  1  analyze-stage hit
- evict_val  in  1  analyze-stage eviction of a valid line
- way_vect  in  `L1_WAY_NUM  hit way or allocated way (one-hot)
- mem_req_val  out  1  line fetch request
- mem_req_addr  out  ADDR_W  line-aligned address
- mem_req_ack  in  1  fetch accepted
- mem_rsp_val  in  1  response beat valid
- mem_rsp_data  in  BEAT_W  response beat
- refill_we  out  1  data array beat write
- refill_way  out  `L1_WAY_NUM  target way, one-hot
- refill_idx  out  `CORE_IDX_WIDTH  target set
- refill_beat  out  log2(LINE_BEATS)  beat position in line
- refill_data  out  BEAT_W  = mem_rsp_data
- refill_tag_we  out  1  tag/valid write, asserted with the last beat
- evict_pulse  out  1  one cycle when an allocated way held a valid line

## Operation
- States: INIT, IDLE, LOOKUP, MISS_REQ, MISS_WAIT, REPLAY.
- INIT: all outputs 0. Moves to IDLE on the first cycle lookup_ready=1.
- IDLE:
  - core_req_rdy=1.
  - On val&rdy, latch the address; lookup_req=1 with lookup_idx taken combinationally from core_req_addr. Go to LOOKUP.
- LOOKUP: sample hit/way_vect.
  - hit=1: core_rsp_val=1, go to IDLE.
  - Otherwise latch way_vect into refill_way, evict_pulse=evict_val, go to MISS_REQ.
- MISS_REQ: mem_req_val=1 with address low bits zeroed. Held until mem_req_ack, then go to MISS_WAIT with the beat counter at 0.
- MISS_WAIT:
  - Each mem_rsp_val: refill_we=1, refill_beat=counter, counter+1.
  - On beat LINE_BEATS-1: refill_tag_we=1, counter wraps to 0, go to REPLAY.
- REPLAY: lookup_req=1 with the latched index, go to LOOKUP. The replay must hit. A replay miss re-enters MISS_REQ (no special case).
- mem_rsp_val outside MISS_WAIT is ignored. mem_req_ack outside MISS_REQ is ignored.
- Only one outstanding miss. core_req_rdy=0 in every state except IDLE.

## Timing
- Reset value of all outputs: 0. State resets to INIT, counter to 0. Asserting reset in any state aborts the miss with no refill writes afterwards.
- Hit latency: request accepted at cycle t, core_rsp_val at t+1. The next request can be accepted at t+2.
- Miss latency: t+1 LOOKUP, t+2 first MISS_REQ cycle, then ack wait, LINE_BEATS beats, 1 REPLAY cycle, 1 LOOKUP cycle.
- Back-to-back beats on consecutive cycles are supported. Gaps are allowed.
- refill_* outputs are combinational from the registered state/counter and from mem_rsp_data.

## Configuration
- L1_MISS_TIMEOUT_EN defined:
  - A cycle counter runs in MISS_WAIT and resets on each beat.
  - When it reaches TIMEOUT_CYC: core_rsp_err=1 for one cycle, no refill_tag_we, go to IDLE.
- Not defined: no counter, core_rsp_err tied to 0, MISS_WAIT waits indefinitely.

## Structure
- Shared package l1_pkg: state enum, LINE_OFFSET_W = log2(LINE_BEATS·BEAT_W/8), and index/tag slice helpers.
- The single file is l1_miss_ctrl. The optional timeout is an instantiated sub-module, l1_miss_timer (clear, enable, expire).

## Test plan
- Reset release with lookup_ready low for 64 cycles → core_req_rdy stays 0 until the cycle after lookup_ready rises.
- Request 0x0000_1040, hit=1 → lookup_idx matches the address index at t, core_rsp_val at t+1, rdy back at t+2.
- Request 0x0000_2000, miss with way_vect=4'b0010 and evict_val=1:
  - expected: evict_pulse=1, mem_req_addr=0x0000_2000 held until ack, 4 beats 0xA0..0xA3 give refill_beat 0..3 with way 0010, refill_tag_we on beat 3.
  - then replay lookup, hit, core_rsp_val.
- Beats with 3-cycle gaps, plus stray mem_rsp_val in IDLE → no refill_we outside MISS_WAIT, counter correct.
- Reset asserted after beat 1 of a miss → all outputs 0 immediately, INIT, no further refill_we.
- With L1_MISS_TIMEOUT_EN and TIMEOUT_CYC=16, no beats after ack → core_rsp_err pulse 16 cycles after MISS_WAIT entry, then IDLE.
